bus_arbiter_2: RTL and testbench
================================

Name: bus_arbiter_2

Overview:
- Two-master arbiter for the shared 9-bit system bus: SRAM at 0x000-0x07F, GPIO mode register at 0x080, GPIO register at 0x100.
- Master 0 is the processor; master 1 is a secondary requester such as a program loader or DMA.
- Grants the bus to one master at a time using round-robin priority.
- Drives the single address/data/write port seen by the IO write decoder and the DIN multiplexer, and routes read data back to the master that issued the read.

Parameters:
- AW, 9, address width.
- DW, 9, data width.
- MAX_HOLD, 16, maximum number of consecutive contested grant cycles; used only with ARB_MAX_HOLD_EN.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1 each  bus request, level-sensitive.
- m0_we, m1_we  in  1 each  1 = write, 0 = read; sampled only while the master's grant is high.
- m0_addr, m1_addr  in  AW each  access address.
- m0_wdata, m1_wdata  in  DW each  write data.
- m0_gnt, m1_gnt  out  1 each  registered grant.
- m0_rvalid, m1_rvalid  out  1 each  read data valid pulse.
- m0_rdata, m1_rdata  out  DW each  read data.
- bus_addr  out  AW  to the write decoder, DIN multiplexer and SRAM address.
- bus_wdata  out  DW  to the DOUT net.
- bus_write  out  1  Write strobe.
- bus_rdata  in  DW  DIN; valid exactly 1 cycle after the read address was presented.

Behaviour:
- Reset values: all gnt/rvalid = 0; bus_write = 0; bus_addr = 0; bus_wdata = 0; rdata = 0; state = IDLE; last_owner = 1, so master 0 wins the first contest.
- Reset in mid-operation: at the next edge, grants drop and any pending rvalid is cancelled.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: if only one master requests, grant it. If both request, grant the master that is not last_owner.
  - Grant latency: request in cycle N gives gnt high from cycle N+1.
  - OWNx: grant holds while mx_req = 1.
  - When mx_req = 0 and the other master is requesting, go directly to OWNy with no dead cycle.
  - When mx_req = 0 and nothing else is requesting, go to IDLE.
  - last_owner updates on every entry to OWNx.
- Simultaneous release by the owner and a new request from the same master: that master is not last-owner-preferred. In a contest the other master wins; with no contest it is re-granted.
- Bus mux:
  - While in OWNx: bus_addr = mx_addr, bus_wdata = mx_wdata, bus_write = mx_we. These are combinational from the registered owner select.
  - In IDLE: all bus outputs are 0 and bus_write = 0.
- Each cycle with gnt = 1 is one bus access.
- Reads:
  - An access with we = 0 sets a one-cycle pipeline flag tagged with the owner.
  - On the next cycle, mx_rvalid = 1 and mx_rdata = bus_rdata for the tagged master, even if ownership has already switched.
  - rdata holds its last value when rvalid = 0.
- Back-to-back reads give rvalid on consecutive cycles.
- Writes produce no rvalid.
- A master that drops req in the same cycle as its last read still receives that read's rvalid.

Optional Feature:
- Macro: ARB_MAX_HOLD_EN.
- Defined:
  - A hold counter increments each cycle the owner keeps its grant while the other master requests.
  - The counter clears on a grant change or when the contest ends.
  - When the count reaches MAX_HOLD-1, ownership is forced to the other master at the next edge, even if the owner's req is still 1.
  - The preempted master re-enters arbitration normally.
- Undefined: no counter exists; the owner holds the bus indefinitely while req = 1.

Decomposition:
- Package nano_bus_pkg:
  - owner_t (M0, M1) and arb_state_t (IDLE, OWN0, OWN1).
  - AW/DW defaults of 9.
  - Region base constants: SRAM_BASE = 9'h000, MODE_ADDR = 9'h080, GPIO_ADDR = 9'h100.
- Sub-module: hold_counter, the saturating contest counter with clear, instantiated only under ARB_MAX_HOLD_EN.

Test Plan:
- Reset, then both req = 1 in cycle 1: m0_gnt = 1 in cycle 2, m1_gnt = 0; bus_addr follows m0_addr.
- Hand-off:
  - Setup: m0 owns the bus, m1_req = 1, m0 drops req in cycle 5.
  - Grant: m1_gnt = 1 in cycle 6 with no idle cycle.
  - Next contest: when both re-request from IDLE, m0 wins.
- Read routing:
  - Setup: m0 reads 0x012 in cycle 3 while DIN = 9'h1A5 in cycle 4; m0 releases in cycle 3 and m1 is granted in cycle 4.
  - Required response: m0_rvalid = 1 and m0_rdata = 9'h1A5 in cycle 4; m1_rvalid = 0.
- Writes: m1 writes 9'h0FF to 0x100, then 9'h003 to 0x080 on consecutive cycles → bus_write high for 2 cycles with matching addr/wdata; no rvalid.
- Reset pulse while m1 is granted with a read in flight → next cycle all gnt = 0 and m1_rvalid = 0; the next contest goes to m0.
- ARB_MAX_HOLD_EN with MAX_HOLD = 4: m0 holds req continuously and m1 requests from cycle 10 → m1_gnt = 1 at cycle 14; m0_gnt returns after m1 releases.

Source files
------------

// File: rtl/nano_bus_pkg.sv
// -----------------------------------------------------------------------------
// nano_bus_pkg
// Shared types and constants for the 9-bit nano system bus.
//   owner_t     : which master owns (or last owned) the bus
//   arb_state_t : arbiter FSM states
//   AW/DW       : default address/data widths
//   SRAM_BASE / SRAM_LAST / MODE_ADDR / GPIO_ADDR : bus memory map
// -----------------------------------------------------------------------------
package nano_bus_pkg;

    localparam int AW_DEFAULT = 9;
    localparam int DW_DEFAULT = 9;

    // Memory map: SRAM 0x000-0x07F, GPIO mode register, GPIO register.
    localparam logic [8:0] SRAM_BASE = 9'h000;
    localparam logic [8:0] SRAM_LAST = 9'h07F;
    localparam logic [8:0] MODE_ADDR = 9'h080;
    localparam logic [8:0] GPIO_ADDR = 9'h100;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // The master that is not `o`; used to pick the contest winner.
    function automatic owner_t other_owner(input owner_t o);
        return (o == M0) ? M1 : M0;
    endfunction

    // FSM state in which master `o` holds the bus.
    function automatic arb_state_t own_state(input owner_t o);
        return (o == M0) ? OWN0 : OWN1;
    endfunction

endpackage

// File: rtl/bus_arbiter_2_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2_if
// Signal bundle between the two requesting masters, the arbiter and the shared
// bus (write decoder / DIN multiplexer / SRAM).
//   modport slave  : the arbiter's view (requests in, grants/bus out)
//   modport master : the requesters' and bus side's view (drives requests and
//                    bus_rdata, observes grants and read responses)
// Signals:
//   m*_req, m*_we, m*_addr, m*_wdata : per-master request side
//   m*_gnt, m*_rvalid, m*_rdata      : per-master response side
//   bus_addr, bus_wdata, bus_write   : muxed shared-bus outputs
//   bus_rdata                        : DIN, valid one cycle after the address
// -----------------------------------------------------------------------------
interface bus_arbiter_2_if #(
    parameter int AW = 9,
    parameter int DW = 9
);
    logic          m0_req;
    logic          m1_req;
    logic          m0_we;
    logic          m1_we;
    logic [AW-1:0] m0_addr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m0_wdata;
    logic [DW-1:0] m1_wdata;

    logic          m0_gnt;
    logic          m1_gnt;
    logic          m0_rvalid;
    logic          m1_rvalid;
    logic [DW-1:0] m0_rdata;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_write;
    logic [DW-1:0] bus_rdata;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we,
        input  m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  bus_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output bus_addr, bus_wdata, bus_write
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we,
        output m0_addr, m1_addr, m0_wdata, m1_wdata,
        output bus_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  bus_addr, bus_wdata, bus_write
    );

endinterface

// File: rtl/bus_arbiter_2_hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
// Saturating count of consecutive contested grant cycles. at_limit is asserted
// once the owner has held the bus for MAX_HOLD-1 contested cycles, which tells
// the arbiter to hand the bus over at the next edge.
// Ports:
//   clock    : system clock
//   reset    : synchronous, active-high
//   clr      : contest ended or grant changed; restart from zero
//   inc      : owner kept the grant while the other master was requesting
//   at_limit : count == MAX_HOLD-1
// -----------------------------------------------------------------------------
module hold_counter #(
    parameter int MAX_HOLD = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam int              CW    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0]   LIMIT = CW'(MAX_HOLD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !at_limit) begin
            count <= count + CW'(1);
        end
    end

    assign at_limit = (count == LIMIT);

endmodule

// File: rtl/bus_arbiter_2.sv
// -----------------------------------------------------------------------------
// bus_arbiter_2
// Round-robin arbiter for the two masters of the 9-bit nano system bus
// (master 0 = processor, master 1 = loader/DMA). Drives the single shared
// address/data/write port and steers read data back to the master that issued
// the read, one cycle after its address was on the bus.
//
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : bus_arbiter_2_if.slave (requests, grants, read responses, bus)
//
// Parameters:
//   AW, DW   : address / data width (must match the interface instance)
//   MAX_HOLD : contested-hold limit, used only when ARB_MAX_HOLD_EN is defined
//
// Build option:
//   ARB_MAX_HOLD_EN : when defined, an owner that keeps the bus for MAX_HOLD-1
//                     contested cycles is preempted in favour of the other
//                     master. When undefined the owner keeps the bus for as
//                     long as it requests.
// -----------------------------------------------------------------------------
module bus_arbiter_2
    import nano_bus_pkg::*;
#(
    parameter int AW       = AW_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter int MAX_HOLD = 16
) (
    input  logic            clock,
    input  logic            reset,
    bus_arbiter_2_if.slave  bus
);

    if (MAX_HOLD < 2) begin : g_max_hold_check
        $error("bus_arbiter_2: MAX_HOLD must be at least 2");
    end

    // -------------------------------------------------------------------------
    // Arbitration FSM
    // -------------------------------------------------------------------------
    arb_state_t state;
    arb_state_t state_next;
    owner_t     last_owner;
    logic       force_handoff;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= M1;       // master 0 wins the first contest
        end else begin
            state <= state_next;
            if (state_next == OWN0) begin
                last_owner <= M0;
            end else if (state_next == OWN1) begin
                last_owner <= M1;
            end
        end
    end

    // NOTE: next-state is defaulted before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
                    state_next = own_state(other_owner(last_owner));
                end else if (bus.m0_req) begin
                    state_next = OWN0;
                end else if (bus.m1_req) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                // Release or preemption hands over directly when master 1 is
                // waiting, without passing through IDLE.
                if (bus.m1_req && (!bus.m0_req || force_handoff)) begin
                    state_next = OWN1;
                end else if (!bus.m0_req) begin
                    state_next = IDLE;
                end
            end
            OWN1: begin
                if (bus.m0_req && (!bus.m1_req || force_handoff)) begin
                    state_next = OWN0;
                end else if (!bus.m1_req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Optional contested-hold limit
    // -------------------------------------------------------------------------
`ifdef ARB_MAX_HOLD_EN
    logic contest;
    logic grant_change;
    logic hold_limit;

    assign contest      = ((state == OWN0) && bus.m1_req) ||
                          ((state == OWN1) && bus.m0_req);
    assign grant_change = (state_next != state);

    hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_counter (
        .clock    (clock),
        .reset    (reset),
        .clr      (!contest || grant_change),
        .inc      (contest && !grant_change),
        .at_limit (hold_limit)
    );

    assign force_handoff = hold_limit && contest;
`else
    assign force_handoff = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Grants and bus multiplexer (combinational from the registered state)
    // -------------------------------------------------------------------------
    logic          granted;
    owner_t        cur_owner;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic          write_mux;

    assign granted    = (state != IDLE);
    assign cur_owner  = (state == OWN1) ? M1 : M0;
    assign bus.m0_gnt = (state == OWN0);
    assign bus.m1_gnt = (state == OWN1);

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        write_mux = 1'b0;
        case (state)
            OWN0: begin
                addr_mux  = bus.m0_addr;
                wdata_mux = bus.m0_wdata;
                write_mux = bus.m0_we;
            end
            OWN1: begin
                addr_mux  = bus.m1_addr;
                wdata_mux = bus.m1_wdata;
                write_mux = bus.m1_we;
            end
            default: ;
        endcase
    end

    assign bus.bus_addr  = addr_mux;
    assign bus.bus_wdata = wdata_mux;
    assign bus.bus_write = write_mux;

    // -------------------------------------------------------------------------
    // Read return path
    // A read access leaves a one-cycle flag tagged with the issuing master.
    // DIN arrives during the following cycle, so the response is steered by
    // the tag rather than the current owner; this keeps a read issued in the
    // last cycle of ownership routed correctly across a hand-off.
    // -------------------------------------------------------------------------
    logic          rd_pend;
    owner_t        rd_tag;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;

    // NOTE: the returned-data holding registers are reset so rdata reads as
    // zero, not X, before the first read completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend    <= 1'b0;
            rd_tag     <= M0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            rd_pend <= granted && !write_mux;
            rd_tag  <= cur_owner;
            if (bus.m0_rvalid) begin
                m0_rdata_q <= bus.bus_rdata;
            end
            if (bus.m1_rvalid) begin
                m1_rdata_q <= bus.bus_rdata;
            end
        end
    end

    assign bus.m0_rvalid = rd_pend && (rd_tag == M0);
    assign bus.m1_rvalid = rd_pend && (rd_tag == M1);
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.bus_rdata : m0_rdata_q;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.bus_rdata : m1_rdata_q;

endmodule

// File: tb/tb_bus_arbiter_2.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_2
// Self-checking bench for bus_arbiter_2: directed sequences with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (owner number, last winner, pending read).
// Honors ARB_MAX_HOLD_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_2;
    import nano_bus_pkg::*;

    localparam int AW       = 9;
    localparam int DW       = 9;
    localparam int MAX_HOLD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   check_en = 1'b0;

    bus_arbiter_2_if #(.AW(AW), .DW(DW)) bif ();

    bus_arbiter_2 #(
        .AW       (AW),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model: owner is -1 (nobody), 0 or 1.
    // ---------------------------------------------------------------------
    int            m_own  = -1;
    int            m_last = 1;
    int            m_tag  = 0;
    int            m_cnt  = 0;
    bit            m_pend = 1'b0;
    logic [DW-1:0] m_held [2] = '{default: '0};

    always @(negedge clock) begin : compare
        bit            r_req [2];
        bit            r_we  [2];
        logic [AW-1:0] r_addr [2];
        logic [DW-1:0] r_wdata [2];
        bit            exp_rv [2];
        logic [DW-1:0] exp_rd [2];
        bit            contest;
        bit            forced;
        int            nxt;

        r_req[0]   = bif.m0_req;   r_req[1]   = bif.m1_req;
        r_we[0]    = bif.m0_we;    r_we[1]    = bif.m1_we;
        r_addr[0]  = bif.m0_addr;  r_addr[1]  = bif.m1_addr;
        r_wdata[0] = bif.m0_wdata; r_wdata[1] = bif.m1_wdata;
        for (int i = 0; i < 2; i++) begin
            exp_rv[i] = m_pend && (m_tag == i);
            exp_rd[i] = exp_rv[i] ? bif.bus_rdata : m_held[i];
        end

        if (check_en) begin
            check("m0_gnt",    bif.m0_gnt,    16'(m_own == 0));
            check("m1_gnt",    bif.m1_gnt,    16'(m_own == 1));
            check("bus_addr",  bif.bus_addr,  (m_own >= 0) ? 16'(r_addr[m_own])  : 16'h0);
            check("bus_wdata", bif.bus_wdata, (m_own >= 0) ? 16'(r_wdata[m_own]) : 16'h0);
            check("bus_write", bif.bus_write, (m_own >= 0) ? 16'(r_we[m_own])    : 16'h0);
            check("m0_rvalid", bif.m0_rvalid, 16'(exp_rv[0]));
            check("m1_rvalid", bif.m1_rvalid, 16'(exp_rv[1]));
            check("m0_rdata",  bif.m0_rdata,  16'(exp_rd[0]));
            check("m1_rdata",  bif.m1_rdata,  16'(exp_rd[1]));
        end

        if (reset) begin
            m_own  = -1;
            m_last = 1;
            m_pend = 1'b0;
            m_cnt  = 0;
            m_held = '{default: '0};
        end else begin
            for (int i = 0; i < 2; i++)
                if (exp_rv[i]) m_held[i] = bif.bus_rdata;
            m_pend  = (m_own >= 0) ? !r_we[m_own] : 1'b0;
            m_tag   = m_own;
            contest = (m_own >= 0) && r_req[1 - m_own];
`ifdef ARB_MAX_HOLD_EN
            forced  = contest && (m_cnt >= MAX_HOLD - 1);
`else
            forced  = 1'b0;
`endif
            if (m_own < 0) begin
                if (r_req[0] && r_req[1]) nxt = 1 - m_last;
                else if (r_req[0])        nxt = 0;
                else if (r_req[1])        nxt = 1;
                else                      nxt = -1;
            end else if (r_req[m_own] && !forced) begin
                nxt = m_own;
            end else if (r_req[1 - m_own]) begin
                nxt = 1 - m_own;
            end else begin
                nxt = -1;
            end
            m_cnt = (contest && nxt == m_own) ? m_cnt + 1 : 0;
            if (nxt >= 0) m_last = nxt;
            m_own = nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers: a cycle starts just after the rising edge, outputs
    // are sampled at the falling edge.
    // ---------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return SRAM_BASE + AW'($urandom_range(0, int'(SRAM_LAST)));
            1:       return MODE_ADDR;
            2:       return GPIO_ADDR;
            default: return AW'($urandom_range(0, 511));
        endcase
    endfunction

    initial begin
        bif.m0_req = 0;  bif.m1_req = 0;
        bif.m0_we  = 1;  bif.m1_we  = 1;
        bif.m0_addr = '0; bif.m1_addr = '0;
        bif.m0_wdata = '0; bif.m1_wdata = '0;
        bif.bus_rdata = '0;
        reset = 1'b1;
        next_cycle();
        check_en = 1'b1;

        // c1: reset values; both masters request.
        reset = 1'b0;
        bif.m0_req = 1; bif.m1_req = 1;
        bif.m0_addr = 9'h012; bif.m0_wdata = 9'h055;
        bif.m1_addr = 9'h100; bif.m1_wdata = 9'h0FF;
        mid();
        check("rst m0_gnt", bif.m0_gnt, 0);
        check("rst m1_gnt", bif.m1_gnt, 0);
        check("rst bus_addr", bif.bus_addr, 0);
        check("rst bus_write", bif.bus_write, 0);
        check("rst m0_rdata", bif.m0_rdata, 0);

        // c2: master 0 wins the first contest.
        next_cycle(); mid();
        check("first m0_gnt", bif.m0_gnt, 1);
        check("first m1_gnt", bif.m1_gnt, 0);
        check("first bus_addr", bif.bus_addr, 9'h012);
        check("first bus_wdata", bif.bus_wdata, 9'h055);

        // c3: master 0 releases while master 1 waits.
        next_cycle(); bif.m0_req = 0; mid();
        check("release m0_gnt", bif.m0_gnt, 1);

        // c4: direct hand-off, then both drop.
        next_cycle(); bif.m1_req = 0; mid();
        check("handoff m1_gnt", bif.m1_gnt, 1);
        check("handoff m0_gnt", bif.m0_gnt, 0);
        check("handoff bus_addr", bif.bus_addr, 9'h100);

        // c5: idle; both re-request.
        next_cycle(); bif.m0_req = 1; bif.m1_req = 1; mid();
        check("idle m1_gnt", bif.m1_gnt, 0);

        // c6: master 0 wins (master 1 owned last); it reads and releases.
        next_cycle();
        bif.m0_req = 0; bif.m0_we = 0; bif.m0_addr = 9'h012;
        mid();
        check("rr m0_gnt", bif.m0_gnt, 1);
        check("rd bus_write", bif.bus_write, 0);

        // c7: read data returns to master 0 while master 1 owns the bus.
        next_cycle(); bif.bus_rdata = 9'h1A5; mid();
        check("rd m0_rvalid", bif.m0_rvalid, 1);
        check("rd m0_rdata", bif.m0_rdata, 9'h1A5);
        check("rd m1_rvalid", bif.m1_rvalid, 0);
        check("rd m1_gnt", bif.m1_gnt, 1);

        // c8/c9: master 1 writes two registers back-to-back.
        next_cycle();
        bif.bus_rdata = 9'h0AA; bif.m0_we = 1;
        bif.m1_addr = GPIO_ADDR; bif.m1_wdata = 9'h0FF;
        mid();
        check("hold m0_rdata", bif.m0_rdata, 9'h1A5);
        check("wr1 bus_write", bif.bus_write, 1);
        check("wr1 bus_addr", bif.bus_addr, 9'h100);
        check("wr1 bus_wdata", bif.bus_wdata, 9'h0FF);
        next_cycle();
        bif.m1_addr = MODE_ADDR; bif.m1_wdata = 9'h003; bif.m1_req = 0;
        mid();
        check("wr2 bus_write", bif.bus_write, 1);
        check("wr2 bus_addr", bif.bus_addr, 9'h080);
        check("wr2 bus_wdata", bif.bus_wdata, 9'h003);
        check("wr2 m1_rvalid", bif.m1_rvalid, 0);

        // c10: idle; master 1 requests alone.
        next_cycle(); bif.m1_req = 1; mid();
        check("wr m1_rvalid", bif.m1_rvalid, 0);

        // c11: master 1 reads while reset pulses.
        next_cycle();
        bif.m1_we = 0; bif.m0_req = 1; reset = 1'b1;
        mid();
        check("pre-rst m1_gnt", bif.m1_gnt, 1);

        // c12: grants and pending read cancelled.
        next_cycle(); reset = 1'b0; bif.m1_we = 1; mid();
        check("post-rst m0_gnt", bif.m0_gnt, 0);
        check("post-rst m1_gnt", bif.m1_gnt, 0);
        check("post-rst m1_rvalid", bif.m1_rvalid, 0);

        // c13: next contest goes to master 0.
        next_cycle(); bif.m1_req = 0; mid();
        check("post-rst contest m0_gnt", bif.m0_gnt, 1);

`ifdef ARB_MAX_HOLD_EN
        // Master 0 keeps requesting; master 1 requests from cycle t.
        next_cycle(); mid();
        next_cycle(); bif.m1_req = 1; mid();
        for (int k = 1; k < 4; k++) begin
            next_cycle(); mid();
        end
        check("hold m0 still owns", bif.m0_gnt, 1);
        next_cycle(); bif.m1_req = 0; mid();
        check("preempt m1_gnt", bif.m1_gnt, 1);
        next_cycle(); mid();
        check("regrant m0_gnt", bif.m0_gnt, 1);
`endif

        // Randomized traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) bif.m0_req = ~bif.m0_req;
            if ($urandom_range(0, 3) == 0) bif.m1_req = ~bif.m1_req;
            bif.m0_we     = 1'($urandom_range(0, 1));
            bif.m1_we     = 1'($urandom_range(0, 1));
            bif.m0_addr   = pick_addr();
            bif.m1_addr   = pick_addr();
            bif.m0_wdata  = DW'($urandom);
            bif.m1_wdata  = DW'($urandom);
            bif.bus_rdata = DW'($urandom);
        end

        next_cycle();
        mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
